logic16_arbiter: RTL and testbench

Shares one 16-bit bitwise logic unit (AND16 / OR16 / NOT16 gate arrays) between two requesters on the Hack-side datapath. Each requester presents an opcode and two 16-bit operands over a valid/ready handshake. A round-robin arbiter grants one requester at a time and drives the operands through the shared unit. The result, tagged with the requester ID and a zero flag, is held on a single response channel until it is consumed.

---
 rtl/logic16_pkg.sv | 23 ++
 rtl/logic16_unit.sv | 67 ++++++
 rtl/logic16_arbiter.sv | 124 ++++++++++++
 tb/tb_logic16_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/logic16_pkg.sv
// logic16_pkg: shared constants for the logic16 arbiter slice.
//   - opcode encoding of the shared bitwise logic unit
//   - 2-bit FSM state encoding of the arbiter
//   - zero-detect helper used for the response zero flag
package logic16_pkg;

  // Opcodes presented on req_op0 / req_op1.
  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_NAND = 2'd2;
  localparam logic [1:0] OP_NOTA = 2'd3;

  // Arbiter FSM states.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // High when a 16-bit word is all zeros.
  function automatic logic is_zero(input logic [15:0] value);
    return (value == 16'h0000);
  endfunction

endpackage

// File: rtl/logic16_unit.sv
// logic16_unit: purely combinational 16-bit bitwise logic unit built from the
// Hack gate arrays (AND16 / OR16 / NOT16) plus an opcode mux.
//   op  in  2 : opcode (AND, OR, NAND, NOT a)
//   a   in 16 : first operand
//   b   in 16 : second operand (ignored for NOT a)
//   out out 16: bitwise result
// The 16-bit gate array primitives g_AND16 / g_OR16 / g_NOT16 live here too.

// g_AND16: 16 parallel AND gates.
module g_AND16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out
);
  assign out = a & b;
endmodule

// g_OR16: 16 parallel OR gates.
module g_OR16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out
);
  assign out = a | b;
endmodule

// g_NOT16: 16 parallel inverters.
module g_NOT16 (
  input  logic [15:0] in,
  output logic [15:0] out
);
  assign out = ~in;
endmodule

module logic16_unit
  import logic16_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out
);

  logic [15:0] and_s;
  logic [15:0] or_s;
  logic [15:0] nand_s;
  logic [15:0] nota_s;

  g_AND16 u_and (.a(a), .b(b), .out(and_s));
  g_OR16  u_or  (.a(a), .b(b), .out(or_s));
  // NAND is the inverted AND16 result, not a separate gate array.
  g_NOT16 u_nand (.in(and_s), .out(nand_s));
  g_NOT16 u_nota (.in(a),     .out(nota_s));

  // Opcode mux selecting one gate-array result.
  always_comb begin
    out = and_s;
    case (op)
      OP_AND:  out = and_s;
      OP_OR:   out = or_s;
      OP_NAND: out = nand_s;
      OP_NOTA: out = nota_s;
      default: out = and_s;
    endcase
  end

endmodule

// File: rtl/logic16_arbiter.sv
// logic16_arbiter: round-robin sharing of one logic16_unit between two
// requesters, with a single held response channel.
//   clk, reset               : clock, asynchronous active-high reset
//   req_valid[1:0]/req_ready : per-requester handshake (ready is one-hot or 0)
//   req_op0/req_a0/req_b0    : requester 0 opcode and operands
//   req_op1/req_a1/req_b1    : requester 1 opcode and operands
//   rsp_valid/rsp_ready      : response handshake
//   rsp_out/rsp_id/rsp_zero  : result, issuing requester, result==0 flag
// Flow: IDLE (grant + capture) -> EXEC (evaluate, register result) -> DONE
// (hold result until consumed) -> IDLE.
module logic16_arbiter
  import logic16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_op0,
  input  logic [1:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_id,
  output logic             rsp_zero
);

  logic [1:0]       state_r;
  logic             last_id_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             id_r;
  logic             rsp_valid_r;
  logic [WIDTH-1:0] rsp_out_r;
  logic             rsp_id_r;
  logic             rsp_zero_r;

  logic [1:0]       grant_s;
  logic [WIDTH-1:0] unit_out_s;

  // Round-robin grant: a lone requester wins; on contention the requester
  // not served last wins. Grants only exist in IDLE and never during reset.
  always_comb begin
    grant_s = 2'b00;
    if (state_r == S_IDLE && !reset) begin
      case (req_valid)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = last_id_r ? 2'b01 : 2'b10;
        default: grant_s = 2'b00;
      endcase
    end else begin
      grant_s = 2'b00;
    end
  end

  assign req_ready = grant_s;

  logic16_unit u_unit (
    .op  (op_r),
    .a   (a_r),
    .b   (b_r),
    .out (unit_out_s)
  );

  // FSM, request capture and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      last_id_r   <= 1'b1;
      op_r        <= OP_AND;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      id_r        <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_out_r   <= {WIDTH{1'b0}};
      rsp_id_r    <= 1'b0;
      rsp_zero_r  <= 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          // grant_s is already masked by req_valid, so any grant is a handshake.
          if (grant_s != 2'b00) begin
            op_r      <= grant_s[1] ? req_op1 : req_op0;
            a_r       <= grant_s[1] ? req_a1  : req_a0;
            b_r       <= grant_s[1] ? req_b1  : req_b0;
            id_r      <= grant_s[1];
            last_id_r <= grant_s[1];
            state_r   <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_out_r   <= unit_out_s;
          rsp_zero_r  <= is_zero(unit_out_s);
          rsp_id_r    <= id_r;
          rsp_valid_r <= 1'b1;
          state_r     <= S_DONE;
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_out   = rsp_out_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_zero  = rsp_zero_r;

endmodule

// File: tb/tb_logic16_arbiter.sv
// tb_logic16_arbiter: directed-vector bench for logic16_arbiter. Inputs are
// driven 1 time unit after the rising edge and outputs are checked there,
// away from the active edge.
module tb_logic16_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_op0, req_op1;
  logic [15:0] req_a0, req_b0, req_a1, req_b1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_out;
  logic        rsp_id;
  logic        rsp_zero;

  int vectors    = 0;
  int miscompares = 0;

  logic16_arbiter #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_id    (rsp_id),
    .rsp_zero  (rsp_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All outputs at their reset values.
  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"}, {14'd0, req_ready}, 16'h0000);
    check({tag, ".rsp_valid"}, {15'd0, rsp_valid}, 16'h0000);
    check({tag, ".rsp_out"},   rsp_out,            16'h0000);
    check({tag, ".rsp_id"},    {15'd0, rsp_id},    16'h0000);
    check({tag, ".rsp_zero"},  {15'd0, rsp_zero},  16'h0001);
  endtask

  // One full transaction with rsp_ready high: grant in IDLE, EXEC, DONE,
  // then back to IDLE. req_valid stays at v throughout.
  task automatic run(input string tag, input logic [1:0] v, input logic [1:0] exp_grant,
                     input logic [15:0] exp_out, input logic exp_id, input logic exp_zero);
    req_valid = v;
    rsp_ready = 1'b1;
    #1;
    check({tag, ".grant"}, {14'd0, req_ready}, {14'd0, exp_grant});
    check({tag, ".onehot_idle"}, {15'd0, $onehot0(req_ready)}, 16'h0001);
    tick();  // EXEC
    check({tag, ".exec_ready"}, {14'd0, req_ready}, 16'h0000);
    check({tag, ".exec_valid"}, {15'd0, rsp_valid}, 16'h0000);
    tick();  // DONE
    check({tag, ".rsp_valid"}, {15'd0, rsp_valid}, 16'h0001);
    check({tag, ".rsp_out"},   rsp_out,            exp_out);
    check({tag, ".rsp_id"},    {15'd0, rsp_id},    {15'd0, exp_id});
    check({tag, ".rsp_zero"},  {15'd0, rsp_zero},  {15'd0, exp_zero});
    check({tag, ".done_ready"}, {14'd0, req_ready}, 16'h0000);
    tick();  // IDLE again
    check({tag, ".idle_valid"}, {15'd0, rsp_valid}, 16'h0000);
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b01; rsp_ready = 1'b0;
    req_op0 = 2'd0; req_op1 = 2'd0;
    req_a0 = 16'h0000; req_b0 = 16'h0000; req_a1 = 16'h0000; req_b1 = 16'h0000;

    // Reset state, with a request pending that must not be granted.
    tick(); tick();
    check_reset_outputs("reset");
    reset = 1'b0;

    // Single request: AND F0F0 & FF00 = F000 from requester 0.
    req_op0 = 2'd0; req_a0 = 16'hF0F0; req_b0 = 16'hFF00;
    run("single", 2'b01, 2'b01, 16'hF000, 1'b0, 1'b0);
    req_valid = 2'b00;

    // Contention from reset: r0 OR 1234|00F0 = 12F4, r1 NOT FFFF = 0000.
    reset = 1'b1; tick(); reset = 1'b0;
    req_op0 = 2'd1; req_a0 = 16'h1234; req_b0 = 16'h00F0;
    req_op1 = 2'd3; req_a1 = 16'hFFFF; req_b1 = 16'h1234;
    run("cont0", 2'b11, 2'b01, 16'h12F4, 1'b0, 1'b0);
    run("cont1", 2'b11, 2'b10, 16'h0000, 1'b1, 1'b1);
    run("cont2", 2'b11, 2'b01, 16'h12F4, 1'b0, 1'b0);
    req_valid = 2'b00;

    // Back-pressure: r1 AND FFFF & 0F0F = 0F0F held for 10 cycles.
    req_op1 = 2'd0; req_a1 = 16'hFFFF; req_b1 = 16'h0F0F;
    rsp_ready = 1'b0;
    req_valid = 2'b10;
    #1;
    check("bp.grant", {14'd0, req_ready}, 16'h0002);
    tick();
    req_valid = 2'b00;
    tick();
    for (int i = 0; i < 10; i++) begin
      req_valid = 2'b11;  // contending requests must be back-pressured
      #1;
      check("bp.rsp_valid", {15'd0, rsp_valid}, 16'h0001);
      check("bp.rsp_out",   rsp_out,            16'h0F0F);
      check("bp.rsp_id",    {15'd0, rsp_id},    16'h0001);
      check("bp.rsp_zero",  {15'd0, rsp_zero},  16'h0000);
      check("bp.req_ready", {14'd0, req_ready}, 16'h0000);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick();
    check("bp.release", {15'd0, rsp_valid}, 16'h0000);
    tick();
    check("bp.single_hs", {15'd0, rsp_valid}, 16'h0000);

    // Op coverage with a=AAAA, b=5555 from requester 0.
    req_a0 = 16'hAAAA; req_b0 = 16'h5555;
    req_op0 = 2'd0; run("op_and",  2'b01, 2'b01, 16'h0000, 1'b0, 1'b1);
    req_op0 = 2'd1; run("op_or",   2'b01, 2'b01, 16'hFFFF, 1'b0, 1'b0);
    req_op0 = 2'd2; run("op_nand", 2'b01, 2'b01, 16'hFFFF, 1'b0, 1'b0);
    req_op0 = 2'd3; run("op_nota", 2'b01, 2'b01, 16'h5555, 1'b0, 1'b0);
    req_valid = 2'b00;

    // Reset in EXEC: transaction from r1 discarded, outputs reset at once.
    req_op1 = 2'd1; req_a1 = 16'h0F00; req_b1 = 16'h00F0;
    req_valid = 2'b10;
    #1;
    check("rexec.grant", {14'd0, req_ready}, 16'h0002);
    tick();  // EXEC
    req_valid = 2'b00;
    reset = 1'b1;
    #1;
    check_reset_outputs("rexec");
    tick();
    reset = 1'b0;
    tick();
    check("rexec.no_rsp", {15'd0, rsp_valid}, 16'h0000);
    run("rexec.retry", 2'b10, 2'b10, 16'h0FF0, 1'b1, 1'b0);
    req_valid = 2'b00;

    // Withdrawn request: r1 pulses valid only while r0's result sits in DONE.
    req_op0 = 2'd0; req_a0 = 16'h00FF; req_b0 = 16'h0FF0;
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();  // DONE
    check("wd.rsp_out", rsp_out, 16'h00F0);
    req_valid = 2'b10;
    #1;
    check("wd.no_grant0", {14'd0, req_ready}, 16'h0000);
    tick();
    check("wd.no_grant1", {14'd0, req_ready}, 16'h0000);
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick();  // IDLE
    check("wd.idle_ready", {14'd0, req_ready}, 16'h0000);
    check("wd.idle_valid", {15'd0, rsp_valid}, 16'h0000);
    tick(); tick();
    check("wd.no_rsp", {15'd0, rsp_valid}, 16'h0000);
    check("wd.id_kept", {15'd0, rsp_id}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
